id_ex_pipeline_reg: RTL and testbench
=====================================

Name: id_ex_pipeline_reg

Overview:
Decode-to-execute pipeline register of the 5-stage RV32I core. It captures the decode-stage control bundle (RegWriteD, MemWriteD, ResultSrcD, ALUControlD, ALUSrcD, BranchD, JumpD) together with operands, register indices and PC values, and presents them to the execute stage as *E signals. It supports hazard-unit stall (hold) and flush (bubble insert), and keeps a saturating count of inserted bubbles for performance monitoring.

Parameters:
XLEN, 32, datapath width for RD1/RD2/PC/PCPlus4/ImmExt
CNT_W, 16, width of the bubble counter

Ports:
clk  in  1  core clock, rising-edge active
reset  in  1  synchronous, active-high reset
StallE  in  1  hold current contents (hazard unit)
FlushE  in  1  load a bubble (hazard unit)
ValidD  in  1  decode slot holds a real instruction
RegWriteD, MemWriteD, ALUSrcD, BranchD, JumpD  in  1 each  decode control
ResultSrcD  in  2  result source select
ALUControlD  in  3  ALU operation
Funct3D  in  3  instr[14:12], for branch condition and load/store size
RD1D, RD2D  in  XLEN  register-file read data
PCD, PCPlus4D, ImmExtD  in  XLEN  PC, PC+4, extended immediate
Rs1D, Rs2D, RdD  in  5 each  register indices
ValidE  out  1  execute slot holds a real instruction
RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE  out  1 each  registered control
ResultSrcE  out  2; ALUControlE  out  3; Funct3E  out  3
RD1E, RD2E, PCE, PCPlus4E, ImmExtE  out  XLEN each
Rs1E, Rs2E, RdE  out  5 each
BubbleCount  out  CNT_W  number of bubbles inserted since reset, saturating

Behaviour:
- All outputs are registers updated only on the rising edge of clk. Latency is one cycle from D inputs to E outputs. There is no combinational path from any input to any output.
- Per-edge priority: reset > FlushE > StallE > load.
- reset=1: every output goes to 0, including ValidE, all control bits, data fields, indices and BubbleCount.
- Bubble, taken when FlushE=1 (regardless of StallE): ValidE, RegWriteE, MemWriteE, BranchE, JumpE and ALUSrcE go to 0. ResultSrcE=00, ALUControlE=000, Funct3E=000. All data fields and Rs1E/Rs2E/RdE go to 0, so a bubble never matches a forwarding or hazard compare against x0 with write enabled.
- FlushE=1 also increments BubbleCount by 1; it saturates at 2^CNT_W-1 and does not wrap.
- StallE=1, FlushE=0: all E outputs and BubbleCount hold their values.
- Load, taken when StallE=0 and FlushE=0: every E output takes its D input, and ValidE=ValidD.
- Invalid input: when ValidD=0 on a load, ValidE=0 but the other fields load unchanged. The block does not gate them; gating is the job of the upstream decode path.
- Reset asserted while StallE or FlushE is high: reset wins, and BubbleCount is not incremented that cycle.
- After reset deasserts, the first edge with StallE=0 and FlushE=0 loads normally. No warm-up cycles.

Test Plan:
1. Reset: reset=1 for 2 cycles with all D inputs at all-ones, then release with StallE=FlushE=0 -> during reset every E output and BubbleCount=0; the first post-release edge loads all-ones values with ValidE=1.
2. Load: a sequence of 4 instructions, e.g. lw with RegWriteD=1, ResultSrcD=01, ALUSrcD=1, RdD=5, ImmExtD=0x10 -> each appears on the E outputs exactly one edge later, unchanged.
3. Stall: load an add with RdD=3, then assert StallE for 3 cycles while the D inputs change -> E outputs keep RdE=3 and add controls for all 3 cycles; BubbleCount is unchanged.
4. Flush: FlushE=1 with a sw on D (MemWriteD=1) -> next edge MemWriteE=0, ValidE=0, RdE=0, BubbleCount increments by 1.
5. Flush beats stall: StallE=1 and FlushE=1 together -> a bubble is inserted, not a hold, and BubbleCount increments.
6. Saturation: with CNT_W=4, apply 20 consecutive flushes -> BubbleCount reaches 15 and stays at 15. A later reset returns it to 0.

Source files
------------

// File: rtl/id_ex_pipeline_reg.sv
// id_ex_pipeline_reg: decode-to-execute pipeline register with stall, flush and a saturating bubble counter
module id_ex_pipeline_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             ValidD,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             ALUSrcD,
  input  logic             BranchD,
  input  logic             JumpD,
  input  logic [1:0]       ResultSrcD,
  input  logic [2:0]       ALUControlD,
  input  logic [2:0]       Funct3D,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  output logic             ValidE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             ALUSrcE,
  output logic             BranchE,
  output logic             JumpE,
  output logic [1:0]       ResultSrcE,
  output logic [2:0]       ALUControlE,
  output logic [2:0]       Funct3E,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic [CNT_W-1:0] BubbleCount
);
  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_write;
    logic            alu_src;
    logic            branch;
    logic            jump;
    logic [1:0]      result_src;
    logic [2:0]      alu_control;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] imm_ext;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } ex_t;
  ex_t d_in, e_d, e_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  always_comb begin
    d_in  = '{valid: ValidD, reg_write: RegWriteD, mem_write: MemWriteD, alu_src: ALUSrcD,
              branch: BranchD, jump: JumpD, result_src: ResultSrcD, alu_control: ALUControlD,
              funct3: Funct3D, rd1: RD1D, rd2: RD2D, pc: PCD, pc_plus4: PCPlus4D,
              imm_ext: ImmExtD, rs1: Rs1D, rs2: Rs2D, rd: RdD};
    // an all-zero bubble keeps rd=x0 with write disabled, so it never trips forwarding
    e_d   = FlushE ? '0 : StallE ? e_q : d_in;
    cnt_d = (FlushE && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      cnt_q <= cnt_d;
    end
  end
  assign ValidE      = e_q.valid;
  assign RegWriteE   = e_q.reg_write;
  assign MemWriteE   = e_q.mem_write;
  assign ALUSrcE     = e_q.alu_src;
  assign BranchE     = e_q.branch;
  assign JumpE       = e_q.jump;
  assign ResultSrcE  = e_q.result_src;
  assign ALUControlE = e_q.alu_control;
  assign Funct3E     = e_q.funct3;
  assign RD1E        = e_q.rd1;
  assign RD2E        = e_q.rd2;
  assign PCE         = e_q.pc;
  assign PCPlus4E    = e_q.pc_plus4;
  assign ImmExtE     = e_q.imm_ext;
  assign Rs1E        = e_q.rs1;
  assign Rs2E        = e_q.rs2;
  assign RdE         = e_q.rd;
  assign BubbleCount = cnt_q;
endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// tb_id_ex_pipeline_reg: directed checks of load, stall, flush, priority and counter saturation
module tb_id_ex_pipeline_reg;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int W     = 6 + 2 + 3 + 3 + 5 * XLEN + 15;
  logic clk = 1'b0, reset, StallE, FlushE;
  logic ValidD, RegWriteD, MemWriteD, ALUSrcD, BranchD, JumpD;
  logic [1:0] ResultSrcD;
  logic [2:0] ALUControlD, Funct3D;
  logic [XLEN-1:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic ValidE, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
  logic [1:0] ResultSrcE;
  logic [2:0] ALUControlE, Funct3E;
  logic [XLEN-1:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic [CNT_W-1:0] BubbleCount;
  logic [W-1:0] obs, v_lw, v_add, v_sw, v_or, v_beq, v_inv;
  int checks = 0, errors = 0, exp_cnt;
  id_ex_pipeline_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD), .BranchD(BranchD),
    .JumpD(JumpD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .Funct3D(Funct3D),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ValidE(ValidE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .BranchE(BranchE), .JumpE(JumpE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .Funct3E(Funct3E), .RD1E(RD1E),
    .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE), .Rs1E(Rs1E),
    .Rs2E(Rs2E), .RdE(RdE), .BubbleCount(BubbleCount)
  );
  always #5 clk = ~clk;
  assign obs = {ValidE, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ResultSrcE, ALUControlE,
                Funct3E, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE};
  function automatic logic [W-1:0] mk(input logic v, rw, mw, as, br, j, input logic [1:0] rs,
      input logic [2:0] alc, f3, input logic [XLEN-1:0] a, b, pc, imm,
      input logic [4:0] r1, r2, rd);
    return {v, rw, mw, as, br, j, rs, alc, f3, a, b, pc, pc + 32'd4, imm, r1, r2, rd};
  endfunction
  task automatic drive(input logic [W-1:0] v);
    {ValidD, RegWriteD, MemWriteD, ALUSrcD, BranchD, JumpD, ResultSrcD, ALUControlD, Funct3D,
     RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD} = v;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [W-1:0] e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, e);
    end
  endtask
  task automatic chk_cnt(input string tag, input int e);
    checks++;
    assert (BubbleCount === CNT_W'(e)) else begin
      errors++;
      $error("FAIL %s count obs=%0d exp=%0d", tag, BubbleCount, e);
    end
  endtask
  initial begin
    v_lw  = mk(1, 1, 0, 1, 0, 0, 2'b01, 3'b000, 3'b010, 32'h1000, 32'h0, 32'h40, 32'h10, 5'd2, 5'd0, 5'd5);
    v_add = mk(1, 1, 0, 0, 0, 0, 2'b00, 3'b000, 3'b000, 32'h7, 32'h9, 32'h44, 32'h0, 5'd1, 5'd2, 5'd3);
    v_sw  = mk(1, 0, 1, 1, 0, 0, 2'b00, 3'b000, 3'b010, 32'h2000, 32'hCAFEF00D, 32'h48, 32'h8, 5'd4, 5'd6, 5'd9);
    v_or  = mk(1, 1, 0, 0, 0, 0, 2'b00, 3'b011, 3'b110, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h4C, 32'h0, 5'd7, 5'd8, 5'd10);
    v_beq = mk(1, 0, 0, 0, 1, 0, 2'b00, 3'b001, 3'b000, 32'h5, 32'h5, 32'h50, 32'hFFFFFFF0, 5'd11, 5'd12, 5'd0);
    v_inv = mk(0, 1, 1, 1, 1, 1, 2'b10, 3'b101, 3'b111, 32'h12345678, 32'h9ABCDEF0, 32'h54, 32'h55, 5'd31, 5'd30, 5'd29);
    reset = 1'b1; StallE = 1'b0; FlushE = 1'b1;
    drive('1);
    tick(); chk("reset_c1", '0); chk_cnt("reset_c1", 0);
    tick(); chk("reset_c2", '0); chk_cnt("reset_c2", 0);
    reset = 1'b0; FlushE = 1'b0;
    tick(); chk("first_load_ones", '1); chk_cnt("first_load_ones", 0);
    drive(v_lw);  tick(); chk("load_lw", v_lw);
    drive(v_or);  tick(); chk("load_or", v_or);
    drive(v_beq); tick(); chk("load_beq", v_beq);
    drive(v_inv); tick(); chk("load_invalid", v_inv); chk_cnt("load_no_incr", 0);
    drive(v_add); tick(); chk("load_add", v_add);
    StallE = 1'b1;
    drive(v_sw);  tick(); chk("stall_c1", v_add);
    drive(v_lw);  tick(); chk("stall_c2", v_add);
    drive(v_inv); tick(); chk("stall_c3", v_add); chk_cnt("stall_cnt", 0);
    StallE = 1'b0; FlushE = 1'b1;
    drive(v_sw);  tick(); chk("flush_sw", '0); chk_cnt("flush_sw", 1);
    FlushE = 1'b0;
    tick(); chk("load_sw", v_sw); chk_cnt("load_sw", 1);
    StallE = 1'b1; FlushE = 1'b1;
    drive(v_or);  tick(); chk("flush_beats_stall", '0); chk_cnt("flush_beats_stall", 2);
    FlushE = 1'b0;
    tick(); chk("stall_holds_bubble", '0); chk_cnt("stall_holds_bubble", 2);
    StallE = 1'b0; FlushE = 1'b1;
    exp_cnt = 2;
    for (int i = 0; i < 20; i++) begin
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      tick(); chk_cnt($sformatf("sat_%0d", i), exp_cnt);
    end
    reset = 1'b1;
    tick(); chk_cnt("reset_clears_count", 0); chk("reset_clears_regs", '0);
    reset = 1'b0; FlushE = 1'b0;
    drive(v_beq); tick(); chk("post_reset_load", v_beq); chk_cnt("post_reset_load", 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
